// File: rtl/seq_signed_multiplier.sv
// Sequential shift-add multiplier with signed/unsigned modes.
// Operands are reduced to magnitudes on acceptance, one multiplier bit is
// consumed per RUN cycle (LSB first), and the sign is reapplied in FIX.
// The request uses a start/busy/done handshake and returns a 2*WIDTH-bit product.
module seq_signed_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     acc_q;
  logic [PW-1:0]     mcand_q;
  logic [WIDTH-1:0]  mplier_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic              busy_q;
  logic              done_q;
  logic [PW-1:0]     product_q;

  logic [WIDTH-1:0]  mag_a_d;
  logic [WIDTH-1:0]  mag_b_d;
  logic              neg_d;
  logic [PW-1:0]     acc_d;
  logic [PW-1:0]     product_d;

  // Operand magnitudes, sign flag, partial-sum update and sign-corrected result.
  always_comb begin
    mag_a_d   = (signed_op & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b_d   = (signed_op & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    neg_d     = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
  end

  // Control FSM and datapath registers.
  // The multiplicand register is shifted left each RUN cycle, which equals
  // adding (mag_a << count) without a barrel shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= PW'(mag_a_d);
            mplier_q <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          product_q <= product_d;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Self-checking bench for seq_signed_multiplier (WIDTH = 32).
module tb_seq_signed_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks;
  int failures;

  seq_signed_multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference: product of the sign- or zero-extended operands modulo 2^64.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic [63:0] xe;
    logic [63:0] ye;
    xe = s ? {{32{x[31]}}, x} : {32'b0, x};
    ye = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is observed.
  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input logic [63:0] exp, input bit pulse);
    int lat;
    bit bad;
    a = ta;
    b = tb_v;
    signed_op = ts;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    signed_op = 1'($urandom);
    lat = 0;
    bad = 0;
    while (!done && lat < 40) begin
      if (!busy) bad = 1;
      start = pulse && (lat == 4 || lat == 19);
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'd33);
    chk({nm, " busy held"}, 64'(bad), 64'd0);
    chk({nm, " product"}, product, exp);
    chk({nm, " busy after done"}, 64'(busy), 64'd0);
  endtask

  // Idle cycles: done and busy low, product held.
  task automatic idle(input string nm, input int n, input logic [63:0] exp);
    bit bad_done;
    bit bad_busy;
    bit bad_prod;
    bad_done = 0;
    bad_busy = 0;
    bad_prod = 0;
    repeat (n) begin
      @(negedge clk);
      if (done !== 1'b0) bad_done = 1;
      if (busy !== 1'b0) bad_busy = 1;
      if (product !== exp) bad_prod = 1;
    end
    chk({nm, " idle done"}, 64'(bad_done), 64'd0);
    chk({nm, " idle busy"}, 64'(bad_busy), 64'd0);
    chk({nm, " idle product held"}, 64'(bad_prod), 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    start = 1'b0;
    signed_op = 1'b0;
    a = '0;
    b = '0;

    vecs.push_back('{32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFEB});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h0000000080000000});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000});
    vecs.push_back('{32'h00000000, 32'hFFFFFFFF, 1'b1, 64'h0000000000000000});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF});
    vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000});

    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset product", product, 64'd0);
    rst = 1'b1;
    idle("post-reset", 10, 64'd0);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b0);
      idle($sformatf("vec%0d", i), 2, vecs[i].exp);
    end

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom);
      if (i % 5 == 0) ra[31] = 1'b1;
      if (i % 7 == 0) rb[31] = 1'b1;
      run_op($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs), 1'b0);
      idle($sformatf("rand%0d", i), 1, model(ra, rb, rs));
    end

    // Start pulses during an op are ignored; then a start in the done cycle is accepted.
    run_op("ignore-start", 32'h00001234, 32'hFFFF0001, 1'b1,
           model(32'h00001234, 32'hFFFF0001, 1'b1), 1'b1);
    run_op("back-to-back", 32'd6, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFFFFFFFFF4, 1'b0);
    idle("back-to-back", 3, 64'hFFFFFFFFFFFFFFF4);

    // Reset mid-operation clears outputs without a clock edge.
    a = 32'd5;
    b = 32'd9;
    signed_op = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid-op busy before reset", 64'(busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset done", 64'(done), 64'd0);
    chk("async reset product", product, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle("after abort", 40, 64'd0);

    run_op("post-abort", 32'hFFFFFF00, 32'h00000100, 1'b1,
           model(32'hFFFFFF00, 32'h00000100, 1'b1), 1'b0);
    idle("post-abort", 2, 64'hFFFFFFFFFFFF0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
